// File: rtl/adc_capture_pkg.sv
// Shared constants and types for the ADC capture engine.
// Widths follow the three-decimator, two-bank 32x512 SRAM configuration.
package adc_capture_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int NCH    = 3;
  localparam int CH_W   = 2;
  localparam int CNT_W  = ADDR_W + 2;

  localparam logic [3:0] WMASK_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } cap_state_t;
endpackage

// File: rtl/adc_capture_if.sv
// Decimator sample inputs and SRAM port-0 write signals of the capture engine.
// master = capture controller, slave = decimators/SRAM side.
interface adc_capture_if;
  import adc_capture_pkg::*;

  logic [NCH-1:0]    adc_dvalid_i;
  logic [DATA_W-1:0] adc0_dat_i;
  logic [DATA_W-1:0] adc1_dat_i;
  logic [DATA_W-1:0] adc2_dat_i;
  logic [1:0]        mem_wenb_o;
  logic [ADDR_W-1:0] mem_waddr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [3:0]        wmask_o;

  // Write strobe semantics: a write happens in the single cycle where one
  // mem_wenb_o bit is low; address, data and mask are valid only then.
  modport master (
    input  adc_dvalid_i, adc0_dat_i, adc1_dat_i, adc2_dat_i,
    output mem_wenb_o, mem_waddr_o, mem_data_o, wmask_o
  );

  modport slave (
    output adc_dvalid_i, adc0_dat_i, adc1_dat_i, adc2_dat_i,
    input  mem_wenb_o, mem_waddr_o, mem_data_o, wmask_o
  );
endinterface

// File: rtl/adc_capture_arb.sv
// Per-channel 1-deep pending registers and a fixed-priority (lowest index) picker.
// A channel being granted this cycle can accept a new sample in the same cycle.
module adc_capture_arb
  import adc_capture_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       accept_i,
  input  logic [NCH-1:0]             ch_en_i,
  input  logic [NCH-1:0]             dvalid_i,
  input  logic [NCH-1:0][DATA_W-1:0] dat_i,
  output logic                       grant_o,
  output logic [CH_W-1:0]            grant_ch_o,
  output logic [DATA_W-1:0]          grant_data_o,
  output logic                       pend_any_o,
  output logic                       drop_o
);
  logic [NCH-1:0]             pend_q, pend_d;
  logic [NCH-1:0][DATA_W-1:0] data_q, data_d;
  logic [NCH-1:0]             take;

  assign take       = {NCH{accept_i}} & ch_en_i & dvalid_i;
  assign pend_any_o = |pend_q;

  // Scan from the top so the lowest pending index is the last to assign.
  always_comb begin
    grant_o      = 1'b0;
    grant_ch_o   = '0;
    grant_data_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_o      = 1'b1;
        grant_ch_o   = CH_W'(i);
        grant_data_o = data_q[i];
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    drop_o = 1'b0;
    if (grant_o) pend_d[grant_ch_o] = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (take[i]) begin
        if (pend_d[i]) begin
          drop_o = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          data_d[i] = dat_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture FSM, ping-pong bank/address counters and status flags.
// Every output, including the SRAM write strobes, comes straight from a register.
module adc_capture_ctrl
  import adc_capture_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [NCH-1:0]    ch_en_i,
  input  logic              continuous_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic [1:0]        bank_clr_i,
  adc_capture_if.master     cap_if,
  output logic              busy_o,
  output logic [1:0]        bank_full_o,
  output logic              overflow_o,
  output logic              done_irq_o,
  output logic [CNT_W-1:0]  wr_count_o,
  output cap_state_t        dbg_state_o
);
  cap_state_t        state_q, state_d;
  logic [NCH-1:0]    ch_en_q, ch_en_d;
  logic              cont_q, cont_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        full_q, full_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic [1:0]        wenb_q, wenb_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;

  logic              accept, armed_hit, wr_ok, wr_last;
  logic              grant, pend_any, drop;
  logic [CH_W-1:0]   grant_ch;
  logic [DATA_W-1:0] grant_data;
  logic [1:0]        full_set;

  assign accept    = ((state_q == ST_ARMED) || (state_q == ST_CAPTURE)) && !stop_i;
  assign armed_hit = |(cap_if.adc_dvalid_i & ch_en_q);

  adc_capture_arb u_arb (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .accept_i     (accept),
    .ch_en_i      (ch_en_q),
    .dvalid_i     (cap_if.adc_dvalid_i),
    .dat_i        ({cap_if.adc2_dat_i, cap_if.adc1_dat_i, cap_if.adc0_dat_i}),
    .grant_o      (grant),
    .grant_ch_o   (grant_ch),
    .grant_data_o (grant_data),
    .pend_any_o   (pend_any),
    .drop_o       (drop)
  );

  // A granted word aimed at a still-full bank is consumed but not written.
  assign wr_ok    = grant && !full_q[bank_q];
  assign wr_last  = (addr_q == last_q);
  assign full_set = (wr_ok && wr_last) ? (2'b01 << bank_q) : 2'b00;

  always_comb begin
    state_d = state_q;
    ch_en_d = ch_en_q;
    cont_d  = cont_q;
    last_d  = last_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    full_d  = (full_q & ~bank_clr_i) | full_set;
    ovf_d   = ovf_q | drop;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wenb_d  = 2'b11;
    wmask_d = 4'h0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (grant) begin
      if (wr_ok) begin
        wenb_d  = ~(2'b01 << bank_q);
        wmask_d = WMASK_ALL;
        waddr_d = addr_q;
        wdata_d = grant_data;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (wr_last) begin
          bank_d = ~bank_q;
          addr_d = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i && (ch_en_i != '0)) begin
          state_d = ST_ARMED;
          ch_en_d = ch_en_i;
          cont_d  = continuous_i;
          // length 0 wraps to all-ones, i.e. a full 512-word bank
          last_d  = ADDR_W'(length_i - (ADDR_W + 1)'(1));
          ovf_d   = 1'b0;
          cnt_d   = '0;
          full_d  = 2'b00;
          bank_d  = 1'b0;
          addr_d  = '0;
        end
      end
      ST_ARMED: begin
        if (stop_i)         state_d = ST_FLUSH;
        else if (armed_hit) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (stop_i || (wr_ok && wr_last && bank_q && !cont_q)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!pend_any) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ch_en_q <= '0;
      cont_q  <= 1'b0;
      last_q  <= '0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      full_q  <= 2'b00;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wenb_q  <= 2'b11;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= 4'h0;
    end else begin
      state_q <= state_d;
      ch_en_q <= ch_en_d;
      cont_q  <= cont_d;
      last_q  <= last_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      wenb_q  <= wenb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign cap_if.mem_wenb_o  = wenb_q;
  assign cap_if.mem_waddr_o = waddr_q;
  assign cap_if.mem_data_o  = wdata_q;
  assign cap_if.wmask_o     = wmask_q;
  assign busy_o             = busy_q;
  assign bank_full_o        = full_q;
  assign overflow_o         = ovf_q;
  assign done_irq_o         = done_q;
  assign wr_count_o         = cnt_q;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the capture rules.
module tb_adc_capture_ctrl;
  import adc_capture_pkg::*;

  localparam int SB_W = 1 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic [NCH-1:0]    ch_en = '0;
  logic [ADDR_W:0]   length = '0;
  logic [1:0]        bank_clr = '0;
  logic              busy, ovf, done;
  logic [1:0]        bank_full;
  logic [CNT_W-1:0]  wr_count;
  cap_state_t        dbg_state;

  adc_capture_if bus();

  adc_capture_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .start_i      (start),
    .stop_i       (stop),
    .ch_en_i      (ch_en),
    .continuous_i (cont),
    .length_i     (length),
    .bank_clr_i   (bank_clr),
    .cap_if       (bus.master),
    .busy_o       (busy),
    .bank_full_o  (bank_full),
    .overflow_o   (ovf),
    .done_irq_o   (done),
    .wr_count_o   (wr_count),
    .dbg_state_o  (dbg_state)
  );

  int n_err = 0;
  int n_checks = 0;
  int done_cnt = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] wlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_phase;  // 0 idle, 1 armed, 2 capture, 3 flush
  bit [NCH-1:0]    m_pend;
  logic [DATA_W-1:0] m_pdat[NCH];
  bit [NCH-1:0]    m_cen;
  bit              m_cont;
  int              m_last, m_bank, m_addr, m_cnt;
  bit [1:0]        m_full;
  bit              m_ovf;
  logic [1:0]        e_wenb;
  logic [3:0]        e_wmask;
  logic [ADDR_W-1:0] e_waddr;
  logic [DATA_W-1:0] e_data;
  bit                e_busy, e_done;

  function automatic logic [DATA_W-1:0] sample(input int i);
    case (i)
      0:       return bus.adc0_dat_i;
      1:       return bus.adc1_dat_i;
      default: return bus.adc2_dat_i;
    endcase
  endfunction

  task automatic m_reset();
    m_phase = 0; m_pend = '0; m_cen = '0; m_cont = 0;
    m_last = 0; m_bank = 0; m_addr = 0; m_cnt = 0; m_full = 0; m_ovf = 0;
    for (int i = 0; i < NCH; i++) m_pdat[i] = '0;
    e_wenb = 2'b11; e_wmask = 4'h0; e_waddr = '0; e_data = '0;
    e_busy = 0; e_done = 0;
    exp_q.delete();
  endtask

  task automatic m_step();
    int g = -1;
    int nphase = m_phase;
    bit [1:0] set = 2'b00;
    bit [NCH-1:0] pend = m_pend;
    e_wenb = 2'b11; e_wmask = 4'h0; e_done = 0;
    for (int i = 0; i < NCH; i++) if (g < 0 && m_pend[i]) g = i;
    if (g >= 0) begin
      pend[g] = 1'b0;
      if (m_full[m_bank]) m_ovf = 1;
      else begin
        e_wenb  = (m_bank == 0) ? 2'b10 : 2'b01;
        e_wmask = 4'hF;
        e_waddr = m_addr[ADDR_W-1:0];
        e_data  = m_pdat[g];
        exp_q.push_back({m_bank[0], e_waddr, e_data});
        if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        if (m_addr == m_last) begin
          set[m_bank] = 1'b1;
          if (!m_cont && m_bank == 1 && m_phase == 2) nphase = 3;
          m_bank = 1 - m_bank;
          m_addr = 0;
        end else m_addr++;
      end
    end
    if ((m_phase == 1 || m_phase == 2) && !stop) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.adc_dvalid_i[i] && m_cen[i]) begin
          if (pend[i]) m_ovf = 1;
          else begin
            pend[i] = 1'b1;
            m_pdat[i] = sample(i);
          end
        end
      end
    end
    m_full = (m_full & ~bank_clr) | set;
    case (m_phase)
      0: if (start && ch_en != 0) begin
        nphase = 1; m_cen = ch_en; m_cont = cont;
        m_last = (length == 0) ? 511 : int'(length) - 1;
        m_ovf = 0; m_cnt = 0; m_full = 0; m_bank = 0; m_addr = 0;
      end
      1: if (stop) nphase = 3; else if ((bus.adc_dvalid_i & m_cen) != 0) nphase = 2;
      2: if (stop) nphase = 3;
      default: if (m_pend == 0) begin nphase = 0; e_done = 1; end
    endcase
    m_pend  = pend;
    m_phase = nphase;
    e_busy  = (nphase != 0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  // ---------------- compare process + write scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [SB_W-1:0] act;
      chk("wenb", bus.mem_wenb_o, e_wenb);
      chk("wmask", bus.wmask_o, e_wmask);
      chk("busy", busy, e_busy);
      chk("bank_full", bank_full, m_full);
      chk("overflow", ovf, m_ovf);
      chk("done_irq", done, e_done);
      chk("wr_count", wr_count, m_cnt);
      if (e_wenb != 2'b11) begin
        chk("waddr", bus.mem_waddr_o, e_waddr);
        chk("wdata", bus.mem_data_o, e_data);
      end
      if (bus.mem_wenb_o != 2'b11) begin
        act = {(bus.mem_wenb_o == 2'b01), bus.mem_waddr_o, bus.mem_data_o};
        wlog.push_back(act);
        if (exp_q.size() == 0) chk("sb_unexpected_write", act, '0);
        else chk("sb_word", act, exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; bank_clr = 2'b00; bus.adc_dvalid_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic arm(input logic [NCH-1:0] en, input logic c, input int len);
    wlog.delete(); done_cnt = 0;
    start = 1'b1; ch_en = en; cont = c; length = (ADDR_W + 1)'(len);
    tick();
  endtask

  task automatic pulse_valid(input logic [NCH-1:0] m, input logic [DATA_W-1:0] d0,
                             input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
    bus.adc_dvalid_i = m; bus.adc0_dat_i = d0; bus.adc1_dat_i = d1; bus.adc2_dat_i = d2;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic stop_wait();
    stop = 1'b1; tick(); wait_idle();
  endtask

  function automatic logic [SB_W-1:0] word(input int b, input int a, input int d);
    return {b[0], a[ADDR_W-1:0], d[DATA_W-1:0]};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.adc_dvalid_i = '0; bus.adc0_dat_i = '0; bus.adc1_dat_i = '0; bus.adc2_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_wenb", bus.mem_wenb_o, 2'b11);
    chk("rst_waddr", bus.mem_waddr_o, 0);
    chk("rst_wdata", bus.mem_data_o, 0);
    chk("rst_wmask", bus.wmask_o, 4'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    idle(2);

    // single shot, ch0, length 4, one valid every 8 cycles
    arm(3'b001, 1'b0, 4);
    for (int k = 0; k < 8; k++) begin
      pulse_valid(3'b001, DATA_W'(32'h100 + k), '0, '0);
      idle(7);
    end
    wait_idle();
    chk("ss_count", wlog.size(), 8);
    for (int k = 0; k < 8 && k < wlog.size(); k++)
      chk("ss_word", wlog[k], word(k / 4, k % 4, 32'h100 + k));
    chk("ss_full", bank_full, 2'b11);
    chk("ss_wr_count", wr_count, 8);
    chk("ss_done_cnt", done_cnt, 1);

    // triple interleave
    arm(3'b111, 1'b0, 16);
    pulse_valid(3'b111, 32'hA, 32'hB, 32'hC);
    idle(4);
    chk("tri_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("tri_w0", wlog[0], word(0, 0, 32'hA));
      chk("tri_w1", wlog[1], word(0, 1, 32'hB));
      chk("tri_w2", wlog[2], word(0, 2, 32'hC));
    end
    chk("tri_ovf", ovf, 1'b0);
    stop_wait();

    // pending overflow: ch2 re-fires while still waiting behind ch0/ch1
    arm(3'b111, 1'b0, 16);
    pulse_valid(3'b111, 32'h1, 32'h2, 32'h3);
    pulse_valid(3'b100, 32'h0, 32'h0, 32'h99);
    idle(4);
    chk("povf_ovf", ovf, 1'b1);
    chk("povf_count", wlog.size(), 3);
    if (wlog.size() == 3) chk("povf_w2", wlog[2], word(0, 2, 32'h3));
    stop_wait();

    // continuous stall, length 2
    arm(3'b001, 1'b1, 2);
    for (int k = 0; k < 5; k++) begin
      pulse_valid(3'b001, DATA_W'(32'h40 + k), '0, '0);
      idle(3);
    end
    chk("stall_count", wlog.size(), 4);
    chk("stall_ovf", ovf, 1'b1);
    chk("stall_full", bank_full, 2'b11);
    bank_clr = 2'b01; tick();
    pulse_valid(3'b001, 32'h55, '0, '0);
    idle(3);
    chk("resume_count", wlog.size(), 5);
    if (wlog.size() == 5) chk("resume_word", wlog[4], word(0, 0, 32'h55));
    stop_wait();

    // stop with ch1 pending
    arm(3'b011, 1'b0, 16);
    pulse_valid(3'b011, 32'h10, 32'h11, '0);
    stop = 1'b1; tick();
    wait_idle();
    chk("stop_count", wlog.size(), 2);
    if (wlog.size() == 2) chk("stop_w1", wlog[1], word(0, 1, 32'h11));
    chk("stop_done_cnt", done_cnt, 1);

    // length 0 means 512 words per bank
    arm(3'b001, 1'b1, 0);
    for (int k = 0; k < 513; k++) begin
      pulse_valid(3'b001, DATA_W'(k), '0, '0);
      idle(1);
    end
    idle(2);
    chk("len0_count", wlog.size(), 513);
    if (wlog.size() == 513) begin
      chk("len0_w511", wlog[511], word(0, 511, 511));
      chk("len0_w512", wlog[512], word(1, 0, 512));
    end
    chk("len0_full", bank_full, 2'b01);
    stop_wait();

    // random traffic against the model
    for (int r = 0; r < 6; r++) begin
      arm(NCH'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), $urandom_range(1, 6));
      for (int c = 0; c < 200; c++) begin
        logic [NCH-1:0] m;
        for (int i = 0; i < NCH; i++) m[i] = ($urandom_range(0, 3) == 0);
        bus.adc_dvalid_i = m;
        bus.adc0_dat_i = $urandom(); bus.adc1_dat_i = $urandom(); bus.adc2_dat_i = $urandom();
        if ($urandom_range(0, 15) == 0) bank_clr = 2'($urandom_range(1, 3));
        if (busy && $urandom_range(0, 31) == 0) begin
          start = 1'b1; ch_en = NCH'($urandom_range(1, 7));
        end
        tick();
      end
      stop_wait();
    end

    // reset asserted while a write is on the bus
    arm(3'b001, 1'b1, 4);
    pulse_valid(3'b001, 32'hDEAD, '0, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_wenb", bus.mem_wenb_o, 2'b11);
    chk("arst_wmask", bus.wmask_o, 4'h0);
    chk("arst_waddr", bus.mem_waddr_o, 0);
    chk("arst_wdata", bus.mem_data_o, 0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_full", bank_full, 2'b00);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_count", wr_count, 0);
    chk("arst_state", dbg_state, ST_IDLE);
    idle(2);
    rst = 1'b0;
    idle(4);
    chk("arst_no_write", wlog.size(), 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
